// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register file write port: round-robin between the ALU (A)
// and load (B) result paths, preceded by an optional zero-fill of registers 1..N-1.
module reg_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  a_pref_q, a_pref_d;
  logic                  wen_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  done_d;
  logic                  grant_a, grant_b;

  // Handshake: a write transfers in any cycle where valid and ready are both high at
  // the posedge; ready depends only on the two valids, the state and the rr pointer.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_RUN) begin
      grant_a = a_valid & (~b_valid | a_pref_q);
      grant_b = b_valid & (~a_valid | ~a_pref_q);
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_pref_d = a_pref_q;
    wen_d    = 1'b0;
    waddr_d  = rf_waddr;
    wdata_d  = rf_wdata;
    done_d   = init_done;
    case (state_q)
      ST_INIT: begin
        wen_d   = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        // Register 0 is hardwired; its writes are accepted but never reach the port.
        if (grant_a) begin
          a_pref_d = 1'b0;
          if (a_addr != '0) begin
            wen_d   = 1'b1;
            waddr_d = a_addr;
            wdata_d = a_data;
          end
        end else if (grant_b) begin
          a_pref_d = 1'b1;
          if (b_addr != '0) begin
            wen_d   = 1'b1;
            waddr_d = b_addr;
            wdata_d = b_data;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT_EN ? ST_INIT : ST_RUN;
      cnt_q     <= ADDR_WIDTH'(1);
      a_pref_q  <= 1'b1;
      rf_wen    <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= ~INIT_EN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_pref_q  <= a_pref_d;
      rf_wen    <= wen_d;
      rf_waddr  <= waddr_d;
      rf_wdata  <= wdata_d;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: init sequence, directed vector table, mid-init reset,
// INIT_EN=0 variant and randomized traffic against a queue-based arbitration model.
module tb_reg_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;
  localparam int EW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst, rst0;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, rf_waddr;
  logic [DW-1:0] a_data, b_data, rf_wdata;
  logic          rf_wen, init_done;

  logic          a0_valid, b0_valid, a0_ready, b0_ready;
  logic [AW-1:0] a0_addr, b0_addr, rf0_waddr;
  logic [DW-1:0] a0_data, b0_data, rf0_wdata;
  logic          rf0_wen, init0_done;

  int checks = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] rf_mirror[NREG];
  logic [DW-1:0] model_rf[NREG];

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ear;
    logic          ebr;
    logic          ewen;
    logic          chk;
    logic [AW-1:0] ewaddr;
    logic [DW-1:0] ewdata;
  } vec_t;

  vec_t tbl[12];

  reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
  );

  reg_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst0),
    .a_valid(a0_valid), .a_ready(a0_ready), .a_addr(a0_addr), .a_data(a0_data),
    .b_valid(b0_valid), .b_ready(b0_ready), .b_addr(b0_addr), .b_data(b0_data),
    .rf_wen(rf0_wen), .rf_waddr(rf0_waddr), .rf_wdata(rf0_wdata), .init_done(init0_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Register file as seen through the write port.
  always @(posedge clk) begin
    if (rf_wen) rf_mirror[rf_waddr] <= rf_wdata;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic ear, input logic ebr, input logic ewen, input logic chk,
                              input logic [AW-1:0] ewaddr, input logic [DW-1:0] ewdata);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.ewen = ewen; v.chk = chk; v.ewaddr = ewaddr; v.ewdata = ewdata;
    return v;
  endfunction

  task automatic drive_idle();
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wen", rf_wen, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    drive_idle();
    rst = 1'b0;
  endtask

  // Expects the zero-fill to start on the first posedge after rst drops.
  task automatic run_init_check(input bit first_hs);
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = AW'($urandom); b_addr = AW'($urandom);
    a_data = $urandom; b_data = $urandom;
    for (int i = 1; i <= NREG - 1; i++) begin
      @(negedge clk);
      check($sformatf("init%0d_wen", i), rf_wen, 1);
      check($sformatf("init%0d_waddr", i), rf_waddr, i);
      check($sformatf("init%0d_wdata", i), rf_wdata, 0);
      check($sformatf("init%0d_done", i), init_done, (i == NREG - 1));
      if (i < NREG - 1) begin
        check($sformatf("init%0d_a_ready", i), a_ready, 0);
        check($sformatf("init%0d_b_ready", i), b_ready, 0);
      end
      if (i == NREG - 2) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
    end
    if (first_hs) begin
      a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h600D;
      #1;
      check("first_hs_a_ready", a_ready, 1);
      check("first_hs_b_ready", b_ready, 0);
    end
    @(negedge clk);
    if (first_hs) begin
      check("first_hs_wen", rf_wen, 1);
      check("first_hs_waddr", rf_waddr, 12);
      check("first_hs_wdata", rf_wdata, 32'h600D);
      a_valid = 1'b0;
    end else begin
      check("post_init_wen", rf_wen, 0);
      check("post_init_waddr_hold", rf_waddr, NREG - 1);
      check("post_init_done", init_done, 1);
    end
  endtask

  task automatic sb_check(input int cyc);
    logic [EW-1:0] e;
    e = exp_q.pop_front();
    check($sformatf("rnd%0d_wen", cyc), rf_wen, e[EW-1]);
    if (e[EW-1]) begin
      check($sformatf("rnd%0d_waddr", cyc), rf_waddr, e[DW +: AW]);
      check($sformatf("rnd%0d_wdata", cyc), rf_wdata, e[DW-1:0]);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 2));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    bit pa, pb, ga, gb, a_pref;
    logic [AW-1:0] pa_addr, pb_addr;
    logic [DW-1:0] pa_data, pb_data;

    for (int r = 0; r < NREG; r++) rf_mirror[r] = 32'h5A5A5A5A;
    rst = 1'b1;
    drive_idle();
    rst0 = 1'b1;
    a0_valid = 1'b0; b0_valid = 1'b0;
    a0_addr = '0; b0_addr = '0; a0_data = '0; b0_data = '0;

    // INIT_EN=0 variant: RUN directly after reset.
    repeat (2) @(negedge clk);
    check("noinit_rst_done", init0_done, 1);
    check("noinit_rst_wen", rf0_wen, 0);
    rst0 = 1'b0;
    a0_valid = 1'b1; a0_addr = 5'd7; a0_data = 32'h1234;
    #1;
    check("noinit_a_ready", a0_ready, 1);
    check("noinit_b_ready", b0_ready, 0);
    @(negedge clk);
    check("noinit_wen", rf0_wen, 1);
    check("noinit_waddr", rf0_waddr, 7);
    check("noinit_wdata", rf0_wdata, 32'h1234);
    check("noinit_done", init0_done, 1);
    a0_valid = 1'b0;
    @(negedge clk);
    check("noinit_idle_wen", rf0_wen, 0);

    // Main instance: reset and zero-fill.
    apply_reset();
    run_init_check(1'b0);
    for (int r = 1; r < NREG; r++) check($sformatf("fill_r%0d", r), rf_mirror[r], 0);
    check("fill_r0_untouched", rf_mirror[0], 32'h5A5A5A5A);

    // Directed vectors; expected write fields describe the cycle after the row.
    tbl[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 31, 0);
    tbl[1]  = mk(1, 3, 32'h11,       1, 3, 32'h22,       1, 0, 1, 1, 3, 32'h11);
    tbl[2]  = mk(1, 3, 32'h12,       1, 3, 32'h22,       0, 1, 1, 1, 3, 32'h22);
    tbl[3]  = mk(1, 3, 32'h12,       1, 3, 32'h23,       1, 0, 1, 1, 3, 32'h12);
    tbl[4]  = mk(1, 3, 32'h13,       1, 3, 32'h23,       0, 1, 1, 1, 3, 32'h23);
    tbl[5]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 1, 5, 32'hDEADBEEF);
    tbl[6]  = mk(0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 9, 32'hAAA,      1, 10, 32'hBBB,     1, 0, 1, 1, 9, 32'hAAA);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 9, 32'hAAA);
    tbl[9]  = mk(1, 11, 32'hCCC,     1, 10, 32'hBBB,     0, 1, 1, 1, 10, 32'hBBB);
    tbl[10] = mk(1, 11, 32'hCCC,     0, 0, 0,            1, 0, 1, 1, 11, 32'hCCC);
    tbl[11] = mk(0, 0, 0,            1, 31, 32'h77,      0, 1, 1, 1, 31, 32'h77);

    for (int k = 0; k < 12; k++) begin
      a_valid = tbl[k].av; a_addr = tbl[k].aa; a_data = tbl[k].ad;
      b_valid = tbl[k].bv; b_addr = tbl[k].ba; b_data = tbl[k].bd;
      #1;
      check($sformatf("tbl%0d_a_ready", k), a_ready, tbl[k].ear);
      check($sformatf("tbl%0d_b_ready", k), b_ready, tbl[k].ebr);
      @(negedge clk);
      check($sformatf("tbl%0d_wen", k), rf_wen, tbl[k].ewen);
      if (tbl[k].chk) begin
        check($sformatf("tbl%0d_waddr", k), rf_waddr, tbl[k].ewaddr);
        check($sformatf("tbl%0d_wdata", k), rf_wdata, tbl[k].ewdata);
      end
    end
    drive_idle();
    @(negedge clk);
    check("tbl_r3", rf_mirror[3], 32'h23);
    check("tbl_r5", rf_mirror[5], 32'hDEADBEEF);
    check("tbl_r0", rf_mirror[0], 32'h5A5A5A5A);
    check("tbl_r9", rf_mirror[9], 32'hAAA);
    check("tbl_r10", rf_mirror[10], 32'hBBB);
    check("tbl_r11", rf_mirror[11], 32'hCCC);
    check("tbl_r31", rf_mirror[31], 32'h77);

    // Reset in the middle of the zero-fill restarts it from register 1.
    apply_reset();
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (rf_wen && rf_waddr == 5'd10) found = 1'b1;
    end
    check("midrst_reached_10", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wen", rf_wen, 0);
    check("midrst_waddr", rf_waddr, 0);
    check("midrst_done", init_done, 0);
    rst = 1'b0;
    run_init_check(1'b1);

    // Randomized traffic against the arbitration model.
    for (int r = 0; r < NREG; r++) model_rf[r] = '0;
    model_rf[0] = 32'h5A5A5A5A;
    model_rf[12] = 32'h600D;
    a_pref = 1'b0;
    pa = 1'b0; pb = 1'b0;
    pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        @(negedge clk);
        sb_check(c - 1);
      end
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1'b1; pa_addr = rand_addr(); pa_data = $urandom;
      end
      if (!pb && $urandom_range(0, 9) < 6) begin
        pb = 1'b1; pb_addr = rand_addr(); pb_data = $urandom;
      end
      a_valid = pa; a_addr = pa ? pa_addr : AW'($urandom); a_data = pa ? pa_data : $urandom;
      b_valid = pb; b_addr = pb ? pb_addr : AW'($urandom); b_data = pb ? pb_data : $urandom;
      ga = pa && (!pb || a_pref);
      gb = pb && !ga;
      #1;
      check($sformatf("rnd%0d_a_ready", c), a_ready, ga);
      check($sformatf("rnd%0d_b_ready", c), b_ready, gb);
      if (ga) begin
        exp_q.push_back({pa_addr != '0, pa_addr, pa_data});
        if (pa_addr != '0) model_rf[pa_addr] = pa_data;
        pa = 1'b0;
        a_pref = 1'b0;
      end else if (gb) begin
        exp_q.push_back({pb_addr != '0, pb_addr, pb_data});
        if (pb_addr != '0) model_rf[pb_addr] = pb_data;
        pb = 1'b0;
        a_pref = 1'b1;
      end else begin
        exp_q.push_back({1'b0, {AW{1'b0}}, {DW{1'b0}}});
      end
    end
    @(negedge clk);
    sb_check(399);
    drive_idle();
    @(negedge clk);
    for (int r = 0; r < NREG; r++) check($sformatf("rnd_final_r%0d", r), rf_mirror[r], model_rf[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Two writeback requesters (A: ALU result path, B: load/memory result path) share that port through valid/ready handshakes.
- Arbitration is round-robin; at most one write per cycle.
- After reset it runs an init sequence that zero-fills registers 1..2^ADDR_WIDTH-1 before it grants any requester.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register address; register count = 2^ADDR_WIDTH.
- INIT_EN, 1, 1 = run the zero-fill sequence after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write.
- a_ready  out  1  A's write accepted this cycle (handshake = a_valid & a_ready).
- a_addr  in  ADDR_WIDTH  A destination register.
- a_data  in  DATA_WIDTH  A write data.
- b_valid  in  1  requester B has a write.
- b_ready  out  1  B's write accepted this cycle.
- b_addr  in  ADDR_WIDTH  B destination register.
- b_data  in  DATA_WIDTH  B write data.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register-file write address (registered).
- rf_wdata  out  DATA_WIDTH  register-file write data (registered).
- init_done  out  1  zero-fill complete; requesters may be granted (registered).

Behaviour:
- Reset (rst=1 at a posedge):
  - state <= INIT if INIT_EN, else RUN.
  - init counter <= 1.
  - rr pointer <= A-preferred.
  - rf_wen <= 0, rf_waddr <= 0, rf_wdata <= 0.
  - init_done <= !INIT_EN.
- Reset mid-operation: a reset during INIT restarts the counter at 1. A reset during RUN drops any write not yet presented on rf_*.
- States: INIT, RUN. No other states; encoding is free.
- INIT, on each posedge with rst=0:
  - rf_wen <= 1, rf_waddr <= counter, rf_wdata <= 0, counter++.
  - When counter == 2^ADDR_WIDTH-1: state <= RUN, init_done <= 1 on that same edge.
  - Result: rf_wen is high for exactly 2^ADDR_WIDTH-1 consecutive cycles (31 at default), addresses 1..31 in order. Address 0 is never written.
  - a_ready = b_ready = 0 throughout INIT.
- RUN, readies are combinational from valids, state and rr pointer:
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester not granted last gets ready=1; the other gets 0.
  - Neither valid: both ready=0.
  - Ready never depends on the requester's addr or data.
  - rr pointer updates only on a completed handshake and points to the winner. Idle cycles leave it unchanged.
- Write latency:
  - A handshake at posedge N (i.e. sampled in the cycle ending at N) gives rf_wen=1 with that addr/data during cycle N..N+1.
  - The register file captures the write at posedge N+1.
  - No handshake: rf_wen <= 0. rf_waddr/rf_wdata hold their previous values.
- Address 0:
  - A handshake with addr 0 is accepted normally (ready=1, rr pointer updates).
  - It produces rf_wen=0 next cycle, so the write is dropped.
- Same address from both requesters in one cycle: only the winner writes this cycle. The loser stays pending and writes in a later cycle, so the last value written is the loser's.
- Back-to-back:
  - A requester held valid while the other is idle is accepted every cycle, giving one write per cycle.
  - With both continuously valid, grants alternate A,B,A,B... (first grant goes to A after reset).
- Requester contract (not checked by this block): a requester keeps valid/addr/data stable until its handshake.
- First RUN handshake: the cycle in which init_done first reads 1 already has readies enabled. The resulting write follows the last init write with no gap.

Test Plan:
- Reset, INIT_EN=1, no valids -> rf_wen high 31 cycles, rf_waddr 1,2,...,31, rf_wdata=0; init_done=1 in the cycle rf_waddr=31; rf_wen=0 afterwards; a_ready=b_ready=0 during INIT.
- After init, a_valid=1 only, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; register file read of r5 returns 0xDEADBEEF.
- Both valid for 4 cycles (a: addr 3 / 0x11, b: addr 3 / 0x22, requesters advance data after each handshake) -> grants A,B,A,B; the rf_wdata sequence matches that order; final r3 equals the last B data.
- b_valid=1, b_addr=0, b_data=0xFFFFFFFF -> b_ready=1, next cycle rf_wen=0; r0 still reads 0.
- rst asserted when rf_waddr=10 during INIT, then released -> the sequence restarts at rf_waddr=1 and runs a full 31 cycles before init_done=1.
- INIT_EN=0, reset then a_valid with addr 7 / 0x1234 -> init_done=1 immediately after reset, a_ready=1 in the first cycle, write to r7 one cycle later.
